// File: rtl/cva6_rvfi_serializer.sv
// Compacts CVA6 RVFI commit records into a FIFO, tags them with a retirement
// order number and drains them one per cycle to a single-lane trace sink.

package config_pkg;
    typedef struct packed {
        int unsigned NrCommitPorts;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 32'd2};

    // Minimal record used when the instantiating core does not supply its own type.
    typedef struct packed {
        logic        valid;
        logic        trap;
        logic [31:0] insn;
        logic [63:0] pc_rdata;
    } rvfi_lite_t;
endpackage

module cva6_rvfi_serializer #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg      = config_pkg::cva6_cfg_empty,
    parameter type                   rvfi_instr_t = config_pkg::rvfi_lite_t,
    parameter int unsigned           FifoDepth    = 8
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  rvfi_instr_t [CVA6Cfg.NrCommitPorts-1:0]        rvfi_i,
    output rvfi_instr_t                                    trace_o,
    output logic [63:0]                                    trace_order_o,
    output logic                                           trace_valid_o,
    input  logic                                           trace_ready_i,
    output logic [$clog2(FifoDepth):0]                     fill_o,
    output logic                                           overflow_o,
    output logic [15:0]                                    drop_cnt_o
);

    localparam int unsigned NrPorts = CVA6Cfg.NrCommitPorts;
    localparam int unsigned AW      = $clog2(FifoDepth);
    localparam int unsigned CW      = AW + 1;

    logic [CW-1:0] count_q;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [63:0]   order_q;
    logic          overflow_q;
    logic [15:0]   drop_cnt_q;

    rvfi_instr_t   mem_q     [FifoDepth];
    logic [63:0]   ord_mem_q [FifoDepth];

    logic [CW-1:0] slot [NrPorts];
    logic [CW-1:0] k, free, stored, dropped;
    logic          pop;
    logic [16:0]   drop_sum;

    // slot[i] is the compacted position of port i among this cycle's valid records.
    always_comb begin
        k = '0;
        for (int i = 0; i < NrPorts; i++) begin
            slot[i] = k;
            k       = k + CW'(rvfi_i[i].valid);
        end
        // Free space ignores a same-cycle pop so trace_ready_i never gates acceptance.
        free     = CW'(FifoDepth) - count_q;
        stored   = (k < free) ? k : free;
        dropped  = k - stored;
        pop      = trace_valid_o && trace_ready_i;
        drop_sum = {1'b0, drop_cnt_q} + 17'(dropped);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NrPorts; i++) begin
                if (rvfi_i[i].valid && (slot[i] < free)) begin
                    mem_q[wptr_q + AW'(slot[i])]     <= rvfi_i[i];
                    ord_mem_q[wptr_q + AW'(slot[i])] <= order_q + 64'(slot[i]);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            order_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            count_q <= count_q + stored - CW'(pop);
            wptr_q  <= wptr_q + AW'(stored);
            rptr_q  <= rptr_q + AW'(pop);
            // Dropped records still consume order numbers, leaving a visible gap.
            order_q <= order_q + 64'(k);
            if (dropped != '0) overflow_q <= 1'b1;
            drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    assign trace_valid_o = (count_q != '0);
    assign trace_o       = trace_valid_o ? mem_q[rptr_q] : '0;
    assign trace_order_o = trace_valid_o ? ord_mem_q[rptr_q] : '0;
    assign fill_o        = count_q;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_cva6_rvfi_serializer.sv
// Directed and randomized checks of the RVFI serializer against a queue-based
// model of the push/drop/order/pop rules.

module tb_cva6_rvfi_serializer;
    typedef config_pkg::rvfi_lite_t rvfi_t;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst;
    rvfi_t [1:0]     rvfi;
    rvfi_t           trace;
    logic [63:0]     trace_order;
    logic            trace_valid;
    logic            rdy;
    logic [3:0]      fill;
    logic            ovf;
    logic [15:0]     drop_cnt;

    cva6_rvfi_serializer #(
        .CVA6Cfg      (config_pkg::cva6_cfg_empty),
        .rvfi_instr_t (rvfi_t),
        .FifoDepth    (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rvfi_i        (rvfi),
        .trace_o       (trace),
        .trace_order_o (trace_order),
        .trace_valid_o (trace_valid),
        .trace_ready_i (rdy),
        .fill_o        (fill),
        .overflow_o    (ovf),
        .drop_cnt_o    (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of (record, order) plus counters.
    rvfi_t             mq[$];
    longint unsigned   oq[$];
    longint unsigned   m_order;
    int                m_drop;
    bit                m_ovf;
    int                n_chk, n_fail;
    rvfi_t             z;

    function automatic rvfi_t mk(bit v, longint unsigned pc);
        rvfi_t r;
        r          = '0;
        r.valid    = v;
        r.trap     = 1'($urandom_range(0, 1));
        r.insn     = $urandom;
        r.pc_rdata = pc;
        return r;
    endfunction

    function automatic rvfi_t exp_head();
        return (mq.size() > 0) ? mq[0] : '0;
    endfunction

    function automatic longint unsigned exp_order();
        return (oq.size() > 0) ? oq[0] : 64'd0;
    endfunction

    // Drive one cycle of inputs, advance the model, then settle past the edge.
    task automatic step(input rvfi_t r0, input rvfi_t r1, input bit ready, input bit reset);
        bit    popq;
        int    free;
        rvfi_t r;
        rvfi[0] = r0; rvfi[1] = r1; rdy = ready; rst = reset;
        if (reset) begin
            mq.delete(); oq.delete(); m_order = 0; m_drop = 0; m_ovf = 0;
        end else begin
            popq = (mq.size() > 0) && ready;
            free = DEPTH - mq.size();
            for (int p = 0; p < 2; p++) begin
                r = (p == 0) ? r0 : r1;
                if (r.valid) begin
                    if (free > 0) begin
                        mq.push_back(r); oq.push_back(m_order); free--;
                    end else begin
                        m_drop = (m_drop == 65535) ? 65535 : m_drop + 1;
                        m_ovf  = 1;
                    end
                    m_order++;
                end
            end
            if (popq) begin
                void'(mq.pop_front()); void'(oq.pop_front());
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        step(z, z, 0, 1);
        step(mk(1, 64'h1234), mk(1, 64'h5678), 1, 1);
        n_chk++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", trace_valid); end
        n_chk++; if (fill !== 4'd0) begin n_fail++; $display("FAIL reset_fill: got %0d want 0", fill); end
        n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_chk++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
        n_chk++; if (trace !== rvfi_t'(0)) begin n_fail++; $display("FAIL reset_trace: got %h want 0", trace); end
    endtask

    task automatic test_single_lane();
        longint unsigned pc;
        step(z, z, 0, 1);
        for (int i = 0; i < 3; i++) begin
            pc = 64'h8000_0000 + 64'(4 * i);
            step(mk(1, pc), z, 1, 0);
            n_chk++; if (trace.pc_rdata !== pc) begin n_fail++; $display("FAIL single_pc%0d: got %h want %h", i, trace.pc_rdata, pc); end
            n_chk++; if (trace_order !== 64'(i)) begin n_fail++; $display("FAIL single_order%0d: got %0d want %0d", i, trace_order, i); end
            n_chk++; if (fill > 4'd1) begin n_fail++; $display("FAIL single_fill%0d: got %0d want <=1", i, fill); end
        end
        step(z, z, 1, 0);
        n_chk++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", trace_valid); end
    endtask

    task automatic test_dual_lane();
        step(z, z, 0, 1);
        step(mk(1, 64'hA), mk(1, 64'hB), 0, 0);
        n_chk++; if (trace.pc_rdata !== 64'hA || trace_order !== 64'd0) begin n_fail++; $display("FAIL dual_first: got pc %h ord %0d want A/0", trace.pc_rdata, trace_order); end
        n_chk++; if (fill !== 4'd2) begin n_fail++; $display("FAIL dual_fill: got %0d want 2", fill); end
        step(z, z, 1, 0);
        n_chk++; if (trace.pc_rdata !== 64'hB || trace_order !== 64'd1) begin n_fail++; $display("FAIL dual_second: got pc %h ord %0d want B/1", trace.pc_rdata, trace_order); end
    endtask

    task automatic test_compaction();
        step(z, z, 0, 1);
        step(mk(0, 64'hDEAD), mk(1, 64'hC), 0, 0);
        n_chk++; if (trace.pc_rdata !== 64'hC || trace_order !== 64'd0) begin n_fail++; $display("FAIL compact_head: got pc %h ord %0d want C/0", trace.pc_rdata, trace_order); end
        n_chk++; if (fill !== 4'd1) begin n_fail++; $display("FAIL compact_fill: got %0d want 1", fill); end
    endtask

    task automatic test_overflow();
        step(z, z, 0, 1);
        for (int c = 0; c < 5; c++) step(mk(1, 64'(c * 2)), mk(1, 64'(c * 2 + 1)), 0, 0);
        n_chk++; if (fill !== 4'd8) begin n_fail++; $display("FAIL ovf_fill: got %0d want 8", fill); end
        n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", ovf); end
        n_chk++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_drop: got %0d want 2", drop_cnt); end
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (trace_valid !== 1'b1 || trace_order !== 64'(i)) begin n_fail++; $display("FAIL ovf_drain%0d: got v%b ord %0d want 1/%0d", i, trace_valid, trace_order, i); end
            step(z, z, 1, 0);
        end
        step(mk(1, 64'h99), z, 0, 0);
        n_chk++; if (trace_order !== 64'd10) begin n_fail++; $display("FAIL ovf_gap: got %0d want 10", trace_order); end
    endtask

    task automatic test_full_pop();
        step(z, z, 0, 1);
        for (int c = 0; c < 4; c++) step(mk(1, 64'(c)), mk(1, 64'(c + 16)), 0, 0);
        n_chk++; if (fill !== 4'd8) begin n_fail++; $display("FAIL fullpop_pre: got %0d want 8", fill); end
        step(mk(1, 64'h77), z, 1, 0);
        n_chk++; if (fill !== 4'd7) begin n_fail++; $display("FAIL fullpop_fill: got %0d want 7", fill); end
        n_chk++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL fullpop_drop: got %0d want 1", drop_cnt); end
        n_chk++; if (trace_order !== 64'd1) begin n_fail++; $display("FAIL fullpop_head: got %0d want 1", trace_order); end
    endtask

    task automatic test_reset_mid();
        step(z, z, 0, 1);
        for (int c = 0; c < 5; c++) step(mk(1, 64'(c)), z, 0, 0);
        n_chk++; if (fill !== 4'd5) begin n_fail++; $display("FAIL rstmid_pre: got %0d want 5", fill); end
        step(mk(1, 64'h55), z, 0, 1);
        n_chk++; if (trace_valid !== 1'b0 || fill !== 4'd0 || ovf !== 1'b0) begin n_fail++; $display("FAIL rstmid_state: got v%b fill %0d ovf %b want 0/0/0", trace_valid, fill, ovf); end
        step(mk(1, 64'h66), z, 0, 0);
        n_chk++; if (trace_order !== 64'd0 || trace.pc_rdata !== 64'h66) begin n_fail++; $display("FAIL rstmid_order: got ord %0d pc %h want 0/66", trace_order, trace.pc_rdata); end
    endtask

    task automatic test_random();
        bit ready, reset;
        step(z, z, 0, 1);
        for (int c = 0; c < 400; c++) begin
            ready = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 99) == 0);
            step(mk(1'($urandom_range(0, 1)), {$urandom, $urandom}),
                 mk(1'($urandom_range(0, 1)), {$urandom, $urandom}), ready, reset);
            n_chk++; if (trace_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", c, trace_valid, mq.size() > 0); end
            n_chk++; if (trace !== exp_head()) begin n_fail++; $display("FAIL rnd_trace@%0d: got %h want %h", c, trace, exp_head()); end
            n_chk++; if (trace_order !== exp_order()) begin n_fail++; $display("FAIL rnd_order@%0d: got %0d want %0d", c, trace_order, exp_order()); end
            n_chk++; if (fill !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_fill@%0d: got %0d want %0d", c, fill, mq.size()); end
            n_chk++; if (ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf@%0d: got %b want %b", c, ovf, m_ovf); end
            n_chk++; if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL rnd_drop@%0d: got %0d want %0d", c, drop_cnt, m_drop); end
        end
    endtask

    initial begin
        z = '0; rvfi = '0; rdy = 1'b0; rst = 1'b1;
        n_chk = 0; n_fail = 0; m_order = 0; m_drop = 0; m_ovf = 0;
        #1;
        test_reset();
        test_single_lane();
        test_dual_lane();
        test_compaction();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
